// File: rtl/fll_cfg_master.sv
// Single-access initiator for the FLL configuration port (REQ/ACK/AD/D/Q/WEB).
// Bridges a valid/ready request/response pair onto the FLL handshake, with timeout abort.
module fll_cfg_master #(
  parameter int unsigned AddrWidth     = 4,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned SyncStages    = 2,
  parameter int unsigned FourPhase     = 0,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic                 cfg_req_o,
  input  logic                 cfg_ack_i,
  output logic [AddrWidth-1:0] cfg_addr_o,
  output logic [DataWidth-1:0] cfg_wdata_o,
  output logic                 cfg_web_o,
  input  logic [DataWidth-1:0] cfg_rdata_i
);

  localparam int unsigned        CntWidth     = $clog2(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntMax      = CntWidth'(TimeoutCycles - 1);
  // A level ACK left over from the previous access is still in the synchroniser
  // for SyncStages cycles; four-phase mode already waited for it to clear.
  localparam int unsigned        IgnoreCycles = (FourPhase == 0) ? SyncStages : 0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_NACK,
    RESP
  } state_e;

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [CntWidth-1:0]  cnt_inc;
  logic                 cfg_req_q, cfg_req_d;
  logic [AddrWidth-1:0] cfg_addr_q, cfg_addr_d;
  logic [DataWidth-1:0] cfg_wdata_q, cfg_wdata_d;
  logic                 cfg_web_q, cfg_web_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_error_q, rsp_error_d;
  logic                 ack_s;
  logic                 ack_window;
  logic                 timeout;

  generate
    if (SyncStages == 0) begin : g_nosync
      assign ack_s = cfg_ack_i;
    end else begin : g_sync
      logic [SyncStages-1:0] ack_sync_q, ack_sync_d;

      always_comb begin
        ack_sync_d = (ack_sync_q << 1) | SyncStages'(cfg_ack_i);
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ack_sync_q <= '0;
        end else begin
          ack_sync_q <= ack_sync_d;
        end
      end

      assign ack_s = ack_sync_q[SyncStages-1];
    end
  endgenerate

  assign cnt_inc    = (cnt_q == CntMax) ? cnt_q : cnt_q + CntWidth'(1);
  assign timeout    = (cnt_q == CntMax);
  assign ack_window = (32'(cnt_q) >= IgnoreCycles);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_req_d   = cfg_req_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    cfg_web_d   = cfg_web_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          cfg_addr_d  = req_addr_i;
          cfg_wdata_d = req_wdata_i;
          cfg_web_d   = ~req_write_i;
          cfg_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_inc;
        if (ack_s && ack_window) begin
          cfg_req_d   = 1'b0;
          rsp_rdata_d = cfg_web_q ? cfg_rdata_i : '0;
          rsp_error_d = 1'b0;
          cnt_d       = '0;
          state_d     = (FourPhase != 0) ? WAIT_NACK : RESP;
        end else if (timeout) begin
          cfg_req_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          state_d     = RESP;
        end
      end
      WAIT_NACK: begin
        cnt_d = cnt_inc;
        if (!ack_s) begin
          state_d = RESP;
        end else if (timeout) begin
          rsp_error_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cfg_req_q   <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      cfg_web_q   <= 1'b1;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_req_q   <= cfg_req_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      cfg_web_q   <= cfg_web_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign cfg_req_o   = cfg_req_q;
  assign cfg_addr_o  = cfg_addr_q;
  assign cfg_wdata_o = cfg_wdata_q;
  assign cfg_web_o   = cfg_web_q;

endmodule
